// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one RAM port between the icache and dcache miss paths.
// The dcache wins ties unless it has already taken STARVE_MAX consecutive
// grants while the icache was waiting. Once a grant starts it is held until
// the RAM completes, reports an error, or the owner withdraws its request.
module mem_arbiter #(
    parameter int STARVE_MAX = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic        starve_err
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] SMAX_C  = SW'(STARVE_MAX);
    localparam logic [SW-1:0] ONE_C   = SW'(1);
    localparam logic [SW-1:0] ZERO_C  = SW'(0);
    localparam logic [1:0]    RS_ACCESS = 2'd2;
    localparam logic [1:0]    RS_ERROR  = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IGRANT = 2'd1,
        DGRANT = 2'd2
    } state_t;

    state_t        state_r;
    logic [SW-1:0] dstreak_r;
    logic          starve_err_r;
    logic          dreq_s;
    logic          access_s;
    logic          error_s;

    assign dreq_s     = dREN | dWEN;
    assign access_s   = (ramstate == RS_ACCESS);
    assign error_s    = (ramstate == RS_ERROR);
    assign starve_err = starve_err_r;

    // Read data goes to both caches unconditionally; each wait line qualifies it.
    assign iload = ramload;
    assign dload = ramload;

    // Grant FSM, dcache streak counter and sticky RAM error flag.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r      <= IDLE;
            dstreak_r    <= ZERO_C;
            starve_err_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (dreq_s && iREN && (dstreak_r == SMAX_C)) begin
                        state_r <= IGRANT;
                    end else if (dreq_s) begin
                        state_r <= DGRANT;
                    end else if (iREN) begin
                        state_r <= IGRANT;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                DGRANT: begin
                    if (access_s) begin
                        state_r <= IDLE;
                        // A streak only matters while the icache is waiting.
                        if (!iREN) begin
                            dstreak_r <= ZERO_C;
                        end else if (dstreak_r != SMAX_C) begin
                            dstreak_r <= dstreak_r + ONE_C;
                        end else begin
                            dstreak_r <= dstreak_r;
                        end
                    end else if (error_s) begin
                        starve_err_r <= 1'b1;
                        state_r      <= IDLE;
                    end else if (!dreq_s) begin
                        state_r <= IDLE;
                    end else begin
                        state_r <= DGRANT;
                    end
                end
                IGRANT: begin
                    if (access_s) begin
                        state_r   <= IDLE;
                        dstreak_r <= ZERO_C;
                    end else if (error_s) begin
                        starve_err_r <= 1'b1;
                        state_r      <= IDLE;
                    end else if (!iREN) begin
                        state_r <= IDLE;
                    end else begin
                        state_r <= IGRANT;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // RAM port and wait lines follow the current owner's request combinationally.
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = 32'd0;
        ramstore = 32'd0;
        iwait    = 1'b1;
        dwait    = 1'b1;
        case (state_r)
            DGRANT: begin
                ramREN   = dREN;
                ramWEN   = dWEN;
                ramaddr  = daddr;
                ramstore = dstore;
                dwait    = ~access_s;
            end
            IGRANT: begin
                ramREN   = iREN;
                ramaddr  = iaddr;
                iwait    = ~access_s;
            end
            default: begin
                ramREN = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a randomized
// run compared cycle by cycle against an ownership/streak reference model.
module tb_mem_arbiter;

    localparam int SMAX = 4;
    localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;

    logic        CLK = 1'b0;
    logic        RST;
    logic        iREN, dREN, dWEN;
    logic [31:0] iaddr, daddr, dstore, ramload;
    logic [1:0]  ramstate;
    logic        iwait, dwait, ramREN, ramWEN, starve_err;
    logic [31:0] iload, dload, ramaddr, ramstore;

    int total = 0;
    int bad   = 0;

    // Reference model: who owns the port (0 none, 1 icache, 2 dcache),
    // how many dcache grants completed in a row with icache waiting, error flag.
    int m_own    = 0;
    int m_streak = 0;
    bit m_err    = 1'b0;

    always #5 CLK = ~CLK;

    mem_arbiter #(.STARVE_MAX(SMAX)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
        .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate),
        .starve_err(starve_err)
    );

    task automatic model_update();
        bit dq;
        dq = dREN | dWEN;
        if (RST) begin
            m_own = 0; m_streak = 0; m_err = 1'b0;
        end else if (m_own == 0) begin
            if (dq && iREN && m_streak == SMAX) m_own = 1;
            else if (dq)                        m_own = 2;
            else if (iREN)                      m_own = 1;
        end else begin
            if (ramstate == ACCESS) begin
                if (m_own == 1 || !iREN) m_streak = 0;
                else if (m_streak < SMAX) m_streak = m_streak + 1;
                m_own = 0;
            end else if (ramstate == ERROR) begin
                m_err = 1'b1;
                m_own = 0;
            end else if ((m_own == 2 && !dq) || (m_own == 1 && !iREN)) begin
                m_own = 0;
            end
        end
    endtask

    // One clock: model follows the edge, stimulus resumes on the falling edge.
    task automatic cyc();
        @(posedge CLK);
        model_update();
        @(negedge CLK);
    endtask

    task automatic test_reset();
        RST = 1'b1; iREN = 1'b1; dREN = 1'b1; dWEN = 1'b0;
        iaddr = 32'h4; daddr = 32'h8; dstore = 32'h0; ramload = 32'h0; ramstate = ACCESS;
        for (int k = 0; k < 2; k++) begin
            cyc(); #1;
            total++; if (ramREN !== 1'b0) begin bad++; $display("FAIL reset_ramREN cyc%0d got=%b want=0", k, ramREN); end
            total++; if (iwait !== 1'b1 || dwait !== 1'b1) begin bad++; $display("FAIL reset_waits got=%b%b want=11", iwait, dwait); end
        end
        RST = 1'b0; iREN = 1'b0; dREN = 1'b0; ramstate = FREE;
        cyc(); #1;
        total++; if (starve_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", starve_err); end
        total++; if (ramaddr !== 32'd0 || ramstore !== 32'd0 || ramWEN !== 1'b0) begin bad++; $display("FAIL reset_ram got addr=%h store=%h wen=%b want=0", ramaddr, ramstore, ramWEN); end
    endtask

    task automatic test_ifill();
        iREN = 1'b1; iaddr = 32'h40; ramstate = BUSY; ramload = 32'hDEADBEEF;
        #1;
        total++; if (ramREN !== 1'b0 || iwait !== 1'b1) begin bad++; $display("FAIL ifill_c0 got ren=%b iwait=%b want 0/1", ramREN, iwait); end
        for (int k = 1; k <= 2; k++) begin
            cyc(); #1;
            total++; if (ramaddr !== 32'h40 || ramREN !== 1'b1 || iwait !== 1'b1) begin bad++; $display("FAIL ifill_busy c%0d got addr=%h ren=%b iwait=%b want 40/1/1", k, ramaddr, ramREN, iwait); end
        end
        cyc(); ramstate = ACCESS; #1;
        total++; if (iwait !== 1'b0 || iload !== 32'hDEADBEEF || dwait !== 1'b1) begin bad++; $display("FAIL ifill_done got iwait=%b iload=%h dwait=%b want 0/deadbeef/1", iwait, iload, dwait); end
        cyc(); iREN = 1'b0; ramstate = FREE; #1;
        total++; if (ramREN !== 1'b0 || iwait !== 1'b1 || ramaddr !== 32'd0) begin bad++; $display("FAIL ifill_idle got ren=%b iwait=%b addr=%h want 0/1/0", ramREN, iwait, ramaddr); end
    endtask

    task automatic test_priority();
        iREN = 1'b1; iaddr = 32'h44; dWEN = 1'b1; daddr = 32'h80; dstore = 32'h1234; ramstate = FREE;
        cyc(); ramstate = ACCESS; #1;
        total++; if (ramWEN !== 1'b1 || ramREN !== 1'b0 || ramaddr !== 32'h80 || ramstore !== 32'h1234) begin bad++; $display("FAIL prio_dgrant got wen=%b ren=%b addr=%h store=%h want 1/0/80/1234", ramWEN, ramREN, ramaddr, ramstore); end
        total++; if (dwait !== 1'b0 || iwait !== 1'b1) begin bad++; $display("FAIL prio_dwait got dwait=%b iwait=%b want 0/1", dwait, iwait); end
        cyc(); dWEN = 1'b0; #1;
        total++; if (ramWEN !== 1'b0 || ramREN !== 1'b0 || iwait !== 1'b1) begin bad++; $display("FAIL prio_gap got wen=%b ren=%b iwait=%b want 0/0/1", ramWEN, ramREN, iwait); end
        cyc(); #1;
        total++; if (ramREN !== 1'b1 || ramaddr !== 32'h44 || ramstore !== 32'd0 || iwait !== 1'b0) begin bad++; $display("FAIL prio_igrant got ren=%b addr=%h store=%h iwait=%b want 1/44/0/0", ramREN, ramaddr, ramstore, iwait); end
        cyc(); iREN = 1'b0; ramstate = FREE;
    endtask

    task automatic test_starve();
        int grants[$];
        int want;
        iREN = 1'b1; iaddr = 32'h100; dREN = 1'b1; daddr = 32'h200; ramstate = ACCESS;
        for (int k = 0; k < 20; k++) begin
            #1;
            if (ramREN === 1'b1 && ramaddr === 32'h200) begin
                grants.push_back(2);
                total++; if (dwait !== 1'b0) begin bad++; $display("FAIL starve_dwait cyc%0d got=%b want=0", k, dwait); end
            end else if (ramREN === 1'b1 && ramaddr === 32'h100) begin
                grants.push_back(1);
                total++; if (iwait !== 1'b0) begin bad++; $display("FAIL starve_iwait cyc%0d got=%b want=0", k, iwait); end
            end
            cyc();
        end
        iREN = 1'b0; dREN = 1'b0; ramstate = FREE;
        total++; if (grants.size() != 10) begin bad++; $display("FAIL starve_count got=%0d want=10", grants.size()); end
        for (int g = 0; g < grants.size() && g < 10; g++) begin
            want = ((g % (SMAX + 1)) == SMAX) ? 1 : 2;
            total++; if (grants[g] != want) begin bad++; $display("FAIL starve_order idx%0d got=%0d want=%0d", g, grants[g], want); end
        end
        total++; if (dut.dstreak_r !== '0) begin bad++; $display("FAIL starve_streak got=%0d want=0", dut.dstreak_r); end
        cyc();
    endtask

    task automatic test_abort();
        bit saw_low;
        saw_low = 1'b0;
        dREN = 1'b1; daddr = 32'h300; ramstate = BUSY;
        cyc(); #1;
        total++; if (ramREN !== 1'b1 || ramaddr !== 32'h300) begin bad++; $display("FAIL abort_grant got ren=%b addr=%h want 1/300", ramREN, ramaddr); end
        if (dwait !== 1'b1) saw_low = 1'b1;
        cyc(); dREN = 1'b0; #1;
        total++; if (ramREN !== 1'b0) begin bad++; $display("FAIL abort_drop got ren=%b want=0", ramREN); end
        if (dwait !== 1'b1) saw_low = 1'b1;
        cyc(); ramstate = ACCESS; #1;
        if (dwait !== 1'b1) saw_low = 1'b1;
        total++; if (saw_low || ramaddr !== 32'd0) begin bad++; $display("FAIL abort_idle got dwait_low=%b addr=%h want 0/0", saw_low, ramaddr); end
        ramstate = FREE;
    endtask

    task automatic test_error();
        iREN = 1'b1; iaddr = 32'h500; ramstate = FREE; ramload = 32'hCAFEF00D;
        cyc(); ramstate = ERROR; #1;
        total++; if (iwait !== 1'b1 || ramREN !== 1'b1) begin bad++; $display("FAIL err_wait got iwait=%b ren=%b want 1/1", iwait, ramREN); end
        cyc(); ramstate = FREE; #1;
        total++; if (starve_err !== 1'b1 || ramREN !== 1'b0) begin bad++; $display("FAIL err_flag got err=%b ren=%b want 1/0", starve_err, ramREN); end
        cyc(); ramstate = ACCESS; #1;
        total++; if (iwait !== 1'b0 || iload !== 32'hCAFEF00D) begin bad++; $display("FAIL err_retry got iwait=%b iload=%h want 0/cafef00d", iwait, iload); end
        cyc(); iREN = 1'b0; ramstate = FREE; #1;
        total++; if (starve_err !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b want=1", starve_err); end
    endtask

    task automatic test_random();
        int r;
        logic        e_ren, e_wen, e_iw, e_dw;
        logic [31:0] e_addr, e_store;
        for (int k = 0; k < 400; k++) begin
            iREN = ($urandom_range(0, 3) != 0);
            r = $urandom_range(0, 2);
            dREN = (r == 1); dWEN = (r == 2);
            iaddr = $urandom; daddr = $urandom; dstore = $urandom; ramload = $urandom;
            r = $urandom_range(0, 15);
            ramstate = (r == 0) ? ERROR : (r < 7) ? ACCESS : (r < 12) ? BUSY : FREE;
            #1;
            e_ren = 1'b0; e_wen = 1'b0; e_addr = 32'd0; e_store = 32'd0; e_iw = 1'b1; e_dw = 1'b1;
            if (m_own == 2) begin
                e_ren = dREN; e_wen = dWEN; e_addr = daddr; e_store = dstore; e_dw = (ramstate != ACCESS);
            end else if (m_own == 1) begin
                e_ren = iREN; e_addr = iaddr; e_iw = (ramstate != ACCESS);
            end
            total++; if (ramREN !== e_ren || ramWEN !== e_wen) begin bad++; $display("FAIL rand_en cyc%0d got=%b%b want=%b%b", k, ramREN, ramWEN, e_ren, e_wen); end
            total++; if (ramaddr !== e_addr || ramstore !== e_store) begin bad++; $display("FAIL rand_bus cyc%0d got=%h/%h want=%h/%h", k, ramaddr, ramstore, e_addr, e_store); end
            total++; if (iwait !== e_iw || dwait !== e_dw) begin bad++; $display("FAIL rand_wait cyc%0d got=%b%b want=%b%b", k, iwait, dwait, e_iw, e_dw); end
            total++; if (starve_err !== m_err || iload !== ramload || dload !== ramload) begin bad++; $display("FAIL rand_misc cyc%0d err=%b want=%b", k, starve_err, m_err); end
            cyc();
        end
        iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0; ramstate = FREE;
        cyc(); cyc();
    endtask

    task automatic test_reset_midgrant();
        dREN = 1'b1; daddr = 32'h700; ramstate = BUSY;
        cyc(); #1;
        total++; if (ramREN !== 1'b1) begin bad++; $display("FAIL rmid_grant got ren=%b want=1", ramREN); end
        RST = 1'b1;
        cyc(); #1;
        total++; if (ramREN !== 1'b0 || iwait !== 1'b1 || dwait !== 1'b1 || starve_err !== 1'b0) begin bad++; $display("FAIL rmid_reset got ren=%b iw=%b dw=%b err=%b want 0/1/1/0", ramREN, iwait, dwait, starve_err); end
        RST = 1'b0; dREN = 1'b0;
        cyc();
    endtask

    initial begin
        test_reset();
        test_ifill();
        test_priority();
        test_starve();
        test_abort();
        test_error();
        test_random();
        test_reset_midgrant();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
